// File: rtl/axis_differentiator_pkg.sv
// axis_differentiator_pkg: shared width and sample type for the differentiator
package axis_differentiator_pkg;
  localparam int W = 32;
  typedef logic signed [W-1:0] sample_t;
endpackage

// File: rtl/axis_reg_slice.sv
// axis_reg_slice: one-deep AXI4-Stream output register with valid/ready logic
module axis_reg_slice #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_valid,
  input  logic             i_ready
);
  logic [WIDTH-1:0] r_data;
  logic             r_valid;
  assign o_ready = ~rst & (i_ready | ~r_valid);
  assign o_data  = r_data;
  assign o_valid = r_valid;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data  <= '0;
      r_valid <= 1'b0;
    end else if (i_valid & o_ready) begin
      r_data  <= i_data;
      r_valid <= 1'b1;
    end else if (i_ready) begin
      r_valid <= 1'b0;
    end
  end
endmodule

// File: rtl/axis_differentiator.sv
// axis_differentiator: AXI4-Stream first difference y[n] = x[n] - x[n-1], modulo 2^W
module axis_differentiator
  import axis_differentiator_pkg::*;
#(
  parameter int AXIS_TDATA_WIDTH = W
) (
  input  logic                        aclk,
  input  logic                        areset,
  input  logic                        enable,
  input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
  input  logic                        S_AXIS_tvalid,
  output logic                        S_AXIS_tready,
  output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
  output logic                        M_AXIS_tvalid,
  input  logic                        M_AXIS_tready
);
  logic [AXIS_TDATA_WIDTH-1:0] r_prev;
  logic                        r_primed;
  logic [AXIS_TDATA_WIDTH-1:0] w_y;
  logic                        w_acc;
  assign w_acc = S_AXIS_tvalid & S_AXIS_tready;
  // the first sample after reset only seeds the history, so it emits zero
  always_comb w_y = !enable ? S_AXIS_tdata : r_primed ? S_AXIS_tdata - r_prev : '0;
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_prev   <= '0;
      r_primed <= 1'b0;
    end else if (w_acc) begin
      r_prev   <= S_AXIS_tdata;
      r_primed <= 1'b1;
    end
  end
  axis_reg_slice #(.WIDTH(AXIS_TDATA_WIDTH)) u_slice (
    .clk     (aclk),
    .rst     (areset),
    .i_data  (w_y),
    .i_valid (S_AXIS_tvalid),
    .o_ready (S_AXIS_tready),
    .o_data  (M_AXIS_tdata),
    .o_valid (M_AXIS_tvalid),
    .i_ready (M_AXIS_tready)
  );
endmodule

// File: tb/tb_axis_differentiator.sv
// tb_axis_differentiator: directed and randomized checks against a behavioural model
module tb_axis_differentiator;
  logic        aclk = 1'b0;
  logic        areset = 1'b1;
  logic        enable = 1'b1;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] m_data;
  logic        m_valid;
  logic        m_ready = 1'b1;
  int          errors = 0;
  int          checks = 0;
  logic        started = 1'b0;

  axis_differentiator #(.AXIS_TDATA_WIDTH(32)) dut (
    .aclk          (aclk),
    .areset        (areset),
    .enable        (enable),
    .S_AXIS_tdata  (s_data),
    .S_AXIS_tvalid (s_valid),
    .S_AXIS_tready (s_ready),
    .M_AXIS_tdata  (m_data),
    .M_AXIS_tvalid (m_valid),
    .M_AXIS_tready (m_ready)
  );

  always #5 aclk = ~aclk;

  logic [31:0] e_prev, e_data;
  logic        e_primed, e_valid, e_ready, e_acc;
  assign e_ready = !areset && (m_ready || !e_valid);
  assign e_acc   = s_valid && e_ready;

  always @(posedge aclk) begin
    if (areset) begin
      e_prev <= 0; e_primed <= 0; e_valid <= 0; e_data <= 0;
    end else if (e_acc) begin
      e_data   <= !enable ? s_data : (e_primed ? s_data - e_prev : 32'd0);
      e_prev   <= s_data;
      e_primed <= 1;
      e_valid  <= 1;
    end else if (m_ready) begin
      e_valid <= 0;
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge aclk) if (started) begin
    chk("model_tvalid", {31'd0, m_valid}, {31'd0, e_valid});
    chk("model_tdata", m_data, e_data);
    chk("model_tready", {31'd0, s_ready}, {31'd0, e_ready});
  end

  task automatic drive(input logic v, input logic [31:0] x, input logic en, input logic mr);
    s_valid = v; s_data = x; enable = en; m_ready = mr;
    @(posedge aclk); #1;
  endtask

  task automatic send(input logic [31:0] x, input logic [31:0] exp, input string name);
    drive(1, x, enable, 1);
    chk(name, m_data, exp);
    chk({name, "_v"}, {31'd0, m_valid}, 32'd1);
  endtask

  task automatic do_reset();
    areset = 1; s_valid = 0; m_ready = 1;
    @(posedge aclk); #1;
    chk("rst_tvalid", {31'd0, m_valid}, 32'd0);
    chk("rst_tdata", m_data, 32'd0);
    chk("rst_tready", {31'd0, s_ready}, 32'd0);
    areset = 0;
  endtask

  initial begin
    enable = 1;
    do_reset();
    started = 1;
    send(10, 0, "ramp0"); send(13, 3, "ramp1"); send(20, 7, "ramp2");
    send(20, 0, "ramp3"); send(5, -32'sd15, "ramp4");
    do_reset();
    send(100, 0, "alt0");
    drive(0, 100, 1, 1); chk("alt_gap0", {31'd0, m_valid}, 32'd0);
    send(150, 50, "alt1");
    drive(0, 150, 1, 1); chk("alt_gap1", {31'd0, m_valid}, 32'd0);
    send(90, -32'sd60, "alt2");
    do_reset();
    send(10, 0, "bp0"); send(17, 7, "bp1");
    for (int i = 0; i < 3; i++) begin
      drive(1, 30, 1, 0);
      chk("bp_hold_data", m_data, 7);
      chk("bp_hold_valid", {31'd0, m_valid}, 32'd1);
      chk("bp_sready", {31'd0, s_ready}, 32'd0);
    end
    send(30, 13, "bp_release");
    do_reset();
    send(32'h8000_0000, 0, "wrap0"); send(32'h7FFF_FFFF, 32'hFFFF_FFFF, "wrap1");
    do_reset();
    send(32'h7FFF_FFFF, 0, "wrap2"); send(32'h8000_0000, 32'h0000_0001, "wrap3");
    do_reset();
    enable = 1; send(5, 0, "en0"); send(8, 3, "en1");
    enable = 0; send(20, 20, "en2");
    enable = 1; send(26, 6, "en3");
    do_reset();
    send(1000, 0, "mid0");
    do_reset();
    send(1003, 0, "mid1");
    for (int i = 0; i < 3000; i++) begin
      areset = ($urandom_range(0, 99) == 0);
      drive($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 4) != 0, $urandom_range(0, 2) != 0);
    end
    areset = 0;
    @(negedge aclk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/axis_differentiator.md
Name: axis_differentiator

Overview:
AXI4-Stream first-order differentiator. Each accepted input sample produces one output sample y[n] = x[n] - x[n-1], two's-complement, modulo 2^W.
- Sits in the signal-processing chain between a sample source (e.g. ADC/phase stage) and downstream filters.
- Single clock domain, one registered output stage.

Parameters:
- AXIS_TDATA_WIDTH, 32: width W of input and output tdata; signed two's-complement samples.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  reset, synchronous, active-high.
- enable  in  1  1 = differentiate; 0 = bypass (y = x).
- S_AXIS_tdata  in  W  input sample x[n].
- S_AXIS_tvalid  in  1  input valid.
- S_AXIS_tready  out  1  input ready.
- M_AXIS_tdata  out  W  output sample y[n].
- M_AXIS_tvalid  out  1  output valid.
- M_AXIS_tready  in  1  downstream ready.

Behaviour:
- Reset (areset=1 at posedge): M_AXIS_tvalid=0, M_AXIS_tdata=0, prev register=0, primed flag=0. Reset mid-stream discards any pending output and forgets history.
- Input handshake:
  - S_AXIS_tready = M_AXIS_tready | ~M_AXIS_tvalid, combinational; no combinational path from S_AXIS_tdata to outputs.
  - A sample is accepted when S_AXIS_tvalid & S_AXIS_tready at a posedge.
  - S_AXIS_tready is 0 during reset.
- On accept:
  - enable=1, primed=1: M_AXIS_tdata <= x - prev (W-bit wrap, no saturation).
  - enable=1, primed=0: M_AXIS_tdata <= 0, i.e. the first sample after reset only primes the history.
  - enable=0: M_AXIS_tdata <= x (bypass).
  - In all cases: prev <= x, primed <= 1, M_AXIS_tvalid <= 1.
- Latency: output is valid the cycle after the accepting edge. Throughput is one sample per clock when M_AXIS_tready=1.
- No accept and M_AXIS_tready=1: M_AXIS_tvalid <= 0; tdata holds its last value.
- Backpressure: while M_AXIS_tvalid=1 & M_AXIS_tready=0, M_AXIS_tdata and M_AXIS_tvalid stay stable and no input is accepted.
- Gaps: S_AXIS_tvalid=0 cycles do not advance prev; the difference is always between consecutive accepted samples.
- enable is sampled at the accepting edge. Toggling enable changes no state other than the selection of the next output. History keeps updating while bypassed, so re-enabling immediately gives a correct difference.
- Overflow: 0x7FFFFFFF - 0x80000000 wraps to 0xFFFFFFFF (-1). This is the required behaviour.

Decomposition:
- Package axis_differentiator_pkg holds:
  - localparam default W = 32.
  - typedef sample_t as a signed vector of width W.
- Optional sub-module axis_reg_slice: the one-deep output register carrying the valid/ready logic. The subtractor and history register stay in the top module.

Test Plan:
1. Reset then ramp: x = 10, 13, 20, 20, 5 with tvalid=1 and tready=1 continuously -> outputs 0, 3, 7, 0, -15, each one cycle after its accept; tvalid held 0 while areset=1.
2. Alternating tvalid (1,0,1,0...), x = 100 (held through gap), 150, 90 -> exactly three outputs 0, 50, -60; no output on gap cycles.
3. Backpressure: hold M_AXIS_tready=0 for 3 cycles after an output of 7 -> M_AXIS_tdata stays 7, tvalid stays 1, S_AXIS_tready=0; on release the next sample is differenced against the last accepted sample.
4. Wrap: x = 0x80000000 then 0x7FFFFFFF -> second output 0xFFFFFFFF; x = 0x7FFFFFFF then 0x80000000 -> second output 0x00000001.
5. Enable toggle: enable=1 x=5,8; enable=0 x=20; enable=1 x=26 -> outputs 0, 3, 20, 6.
6. Reset mid-stream after x=1000, then areset pulse, then x=1003 -> pending output dropped; first post-reset output is 0, not 3.
